// File: rtl/adc_scan_controller_if.sv
// adc_scan_controller_if: control, ADC pin and result-stream bundle for the scan controller
interface adc_scan_controller_if;
  logic        scan_en;
  logic [7:0]  chan_mask;
  logic        adc_cs_n;
  logic        adc_sclk;
  logic        adc_saddr;
  logic        adc_sdat;
  logic        sample_valid;
  logic        sample_ready;
  logic [2:0]  sample_chan;
  logic [11:0] sample_data;
  logic        busy;
  modport master (
    input  scan_en, chan_mask, adc_sdat, sample_ready,
    output adc_cs_n, adc_sclk, adc_saddr, sample_valid, sample_chan, sample_data, busy
  );
  modport slave (
    output scan_en, chan_mask, adc_sdat, sample_ready,
    input  adc_cs_n, adc_sclk, adc_saddr, sample_valid, sample_chan, sample_data, busy
  );
endinterface

// File: rtl/adc_scan_controller.sv
// adc_scan_controller: round-robin ADC128S022 scan sequencer with a valid/ready result port
module adc_scan_controller #(
  parameter int CLK_DIV  = 8,
  parameter int NUM_CHAN = 8
) (
  input logic CLK50MHZ,
  input logic reset,
  adc_scan_controller_if.master bus
);
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [1:0] IDLE = 2'd0, SETUP = 2'd1, SHIFT = 2'd2, GAP = 2'd3;
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [3:0]    bitn, nb;
  logic [2:0]    ptr, addr, conv_chan, nxt, idx, chan;
  logic [11:0]   shift, data;
  logic          primed, found, cs_n, sclk, saddr, valid, last, run;
  assign last = cnt == CW'(CLK_DIV - 1);
  assign run  = bus.scan_en && |bus.chan_mask;
  assign nb   = bitn - 4'd1;
  assign bus.adc_cs_n     = cs_n;
  assign bus.adc_sclk     = sclk;
  assign bus.adc_saddr    = saddr;
  assign bus.sample_valid = valid;
  assign bus.sample_chan  = chan;
  assign bus.sample_data  = data;
  assign bus.busy         = state != IDLE;
  // pick the lowest enabled channel at or after the pointer, wrapping 7 -> 0
  always_comb begin
    nxt   = ptr;
    found = 1'b0;
    idx   = ptr;
    for (int i = 0; i < NUM_CHAN; i++) begin
      idx = ptr + 3'(i);
      if (!found && bus.chan_mask[idx]) begin
        nxt   = idx;
        found = 1'b1;
      end
    end
  end
  // frame sequencer: SETUP, 16 SCLK cycles, GAP with result posting and handshake gating
  always_ff @(posedge CLK50MHZ or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bitn      <= '0;
      ptr       <= '0;
      addr      <= '0;
      conv_chan <= '0;
      primed    <= 1'b0;
      shift     <= '0;
      cs_n      <= 1'b1;
      sclk      <= 1'b1;
      saddr     <= 1'b0;
      valid     <= 1'b0;
      chan      <= '0;
      data      <= '0;
    end else begin
      cnt <= last ? '0 : cnt + 1'b1;
      if (valid && bus.sample_ready) valid <= 1'b0;
      case (state)
        IDLE: if (run && !valid) begin
          state <= SETUP;
          cs_n  <= 1'b0;
          addr  <= nxt;
          ptr   <= nxt + 3'd1;
          cnt   <= '0;
        end
        SETUP: if (last) begin
          state <= SHIFT;
          sclk  <= 1'b0;
          bitn  <= 4'd15;
          saddr <= 1'b0;
        end
        SHIFT: if (last) begin
          if (!sclk) begin
            sclk  <= 1'b1;
            shift <= {shift[10:0], bus.adc_sdat};
          end else if (bitn == 4'd0) begin
            state     <= GAP;
            cs_n      <= 1'b1;
            saddr     <= 1'b0;
            primed    <= 1'b1;
            conv_chan <= addr;
            if (primed) begin
              valid <= 1'b1;
              data  <= shift;
              chan  <= conv_chan;
            end
          end else begin
            sclk  <= 1'b0;
            bitn  <= nb;
            saddr <= nb == 4'd13 ? addr[2] : nb == 4'd12 ? addr[1] : nb == 4'd11 ? addr[0] : 1'b0;
          end
        end
        default: if (last) begin
          if (!run) begin
            state  <= IDLE;
            primed <= 1'b0;
          end else if (!(valid && !bus.sample_ready)) begin
            state <= SETUP;
            cs_n  <= 1'b0;
            addr  <= nxt;
            ptr   <= nxt + 3'd1;
          end else cnt <= cnt;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_adc_scan_controller.sv
// tb_adc_scan_controller: directed vector bench with an ADC128S022 behavioural model
module tb_adc_scan_controller;
  typedef struct {
    logic [7:0]  mask;
    logic [2:0]  chan;
    logic [11:0] data;
    logic [2:0]  din;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1;
  adc_scan_controller_if bus();
  adc_scan_controller dut (.CLK50MHZ(clk), .reset(rst), .bus(bus.master));
  always #10 clk = ~clk;
  int nvec = 0, nerr = 0;
  logic [11:0] rom [8];
  int k = 16, cyc = 0, last_fall = 0, period = 0, nfall = 0;
  logic [2:0]  cur_ch = '0, next_ch = '0, last_din = '0;
  logic [15:0] din = '0, word;
  vec_t v [11];
  always @(posedge clk) cyc++;
  always @(negedge bus.adc_cs_n) begin
    k = 0;
    cur_ch = next_ch;
    nfall++;
    period = cyc - last_fall;
    last_fall = cyc;
  end
  always @(negedge bus.adc_sclk) if (!bus.adc_cs_n && k < 16) begin
    word = {4'hA, rom[cur_ch]};
    bus.adc_sdat = word[15-k];
    k++;
  end
  always @(posedge bus.adc_sclk) if (!bus.adc_cs_n && k > 0 && k <= 16) din[16-k] = bus.adc_saddr;
  always @(posedge bus.adc_cs_n) begin
    next_ch  = din[13:11];
    last_din = din[13:11];
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  task automatic restart(input logic [7:0] m);
    @(negedge clk);
    rst = 1'b1;
    bus.scan_en = 1'b0;
    bus.sample_ready = 1'b1;
    bus.chan_mask = m;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    bus.scan_en = 1'b1;
  endtask
  task automatic wait_valid(input string name, input int budget);
    int n = 0;
    while (bus.sample_valid !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (bus.sample_valid !== 1'b1) check({name, "_timeout"}, 0, 1);
  endtask
  initial begin
    int f, bad, n;
    logic [2:0]  sc;
    logic [11:0] sd;
    rom = '{12'h5A0, 12'h111, 12'hABC, 12'h333, 12'h444, 12'h555, 12'h666, 12'hFE7};
    v[0]  = '{8'h04, 3'd2, 12'hABC, 3'd2};
    v[1]  = '{8'h04, 3'd2, 12'hABC, 3'd2};
    v[2]  = '{8'h04, 3'd2, 12'hABC, 3'd2};
    v[3]  = '{8'h81, 3'd0, 12'h5A0, 3'd7};
    v[4]  = '{8'h81, 3'd7, 12'hFE7, 3'd0};
    v[5]  = '{8'h81, 3'd0, 12'h5A0, 3'd7};
    v[6]  = '{8'h81, 3'd7, 12'hFE7, 3'd0};
    v[7]  = '{8'h2A, 3'd1, 12'h111, 3'd3};
    v[8]  = '{8'h2A, 3'd3, 12'h333, 3'd5};
    v[9]  = '{8'h2A, 3'd5, 12'h555, 3'd1};
    v[10] = '{8'h2A, 3'd1, 12'h111, 3'd3};
    bus.adc_sdat = 1'b0;
    bus.scan_en = 1'b0;
    bus.sample_ready = 1'b1;
    bus.chan_mask = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_cs_n", 32'(bus.adc_cs_n), 1);
    check("rst_sclk", 32'(bus.adc_sclk), 1);
    check("rst_saddr", 32'(bus.adc_saddr), 0);
    check("rst_valid", 32'(bus.sample_valid), 0);
    check("rst_chan", 32'(bus.sample_chan), 0);
    check("rst_data", 32'(bus.sample_data), 0);
    check("rst_busy", 32'(bus.busy), 0);
    restart(8'hFF);
    n = 0;
    while (bus.adc_sclk !== 1'b0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("mid_shift_reached", 32'(bus.adc_sclk), 0);
    repeat (20) @(negedge clk);
    #3 rst = 1'b1;
    bus.scan_en = 1'b0;
    #1;
    check("abort_cs_n", 32'(bus.adc_cs_n), 1);
    check("abort_sclk", 32'(bus.adc_sclk), 1);
    check("abort_valid", 32'(bus.sample_valid), 0);
    check("abort_busy", 32'(bus.busy), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    f = nfall;
    bad = 0;
    repeat (600) begin
      @(negedge clk);
      if (bus.sample_valid !== 1'b0 || bus.busy !== 1'b0) bad++;
    end
    check("abort_no_pulse", 32'(nfall - f), 0);
    check("abort_quiet", 32'(bad), 0);
    for (int i = 0; i < 11; i++) begin
      if (i == 0 || v[i].mask != v[i-1].mask) restart(v[i].mask);
      wait_valid($sformatf("vec%0d", i), 2000);
      check($sformatf("vec%0d_chan", i), 32'(bus.sample_chan), 32'(v[i].chan));
      check($sformatf("vec%0d_data", i), 32'(bus.sample_data), 32'(v[i].data));
      check($sformatf("vec%0d_din", i), 32'(last_din), 32'(v[i].din));
      check($sformatf("vec%0d_period", i), 32'(period), 272);
      @(negedge clk);
    end
    restart(8'h81);
    bus.sample_ready = 1'b0;
    wait_valid("stall", 2000);
    check("stall_chan", 32'(bus.sample_chan), 0);
    check("stall_data", 32'(bus.sample_data), 32'h5A0);
    sc = bus.sample_chan;
    sd = bus.sample_data;
    f = nfall;
    bad = 0;
    repeat (2000) begin
      @(negedge clk);
      if (bus.sample_valid !== 1'b1 || bus.sample_chan !== sc || bus.sample_data !== sd || bus.adc_cs_n !== 1'b1) bad++;
    end
    check("stall_hold", 32'(bad), 0);
    check("stall_no_frame", 32'(nfall - f), 0);
    bus.sample_ready = 1'b1;
    @(negedge clk);
    bus.sample_ready = 1'b0;
    check("stall_accept_once", 32'(bus.sample_valid), 0);
    wait_valid("resume", 2000);
    check("resume_chan", 32'(bus.sample_chan), 7);
    check("resume_data", 32'(bus.sample_data), 32'hFE7);
    bus.sample_ready = 1'b1;
    restart(8'h04);
    wait_valid("stop_pre", 2000);
    @(negedge clk);
    n = 0;
    while (!(k == 11 && bus.adc_cs_n === 1'b0) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("stop_bit5_reached", 32'(k), 11);
    bus.scan_en = 1'b0;
    wait_valid("stop_post", 1000);
    check("stop_chan", 32'(bus.sample_chan), 2);
    check("stop_data", 32'(bus.sample_data), 32'hABC);
    repeat (20) @(negedge clk);
    check("stop_busy", 32'(bus.busy), 0);
    f = nfall;
    repeat (600) @(negedge clk);
    check("stop_no_pulse", 32'(nfall - f), 0);
    restart(8'h00);
    f = nfall;
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (bus.busy !== 1'b0) bad++;
    end
    check("mask0_no_pulse", 32'(nfall - f), 0);
    check("mask0_busy", 32'(bad), 0);
    bus.chan_mask = 8'h10;
    wait_valid("mask10", 2000);
    check("mask10_chan", 32'(bus.sample_chan), 4);
    check("mask10_data", 32'(bus.sample_data), 32'h444);
    check("mask10_din", 32'(last_din), 4);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
